// File: rtl/proc_pkg.sv
// Shared definitions for the 20-bit pipelined processor.
//   DATA_W          : datapath / instruction width
//   opcode_e        : opcode encoding (OP_NOP .. OP_ST); codes 10-15 are unused
//   OPC_* / IMM_*   : instruction field bit positions
//   ex_state_e      : execute-stage sequencing states
//   sext_imm8()     : sign-extend the 8-bit immediate to DATA_W
package proc_pkg;

  localparam int DATA_W = 20;

  localparam int OPC_HI = 19;
  localparam int OPC_LO = 16;
  localparam int IMM_HI = 7;
  localparam int IMM_LO = 0;

  typedef enum logic [3:0] {
    OP_NOP  = 4'd0,
    OP_ADD  = 4'd1,
    OP_SUB  = 4'd2,
    OP_AND  = 4'd3,
    OP_OR   = 4'd4,
    OP_SLT  = 4'd5,
    OP_ADDI = 4'd6,
    OP_MUL  = 4'd7,
    OP_LD   = 4'd8,
    OP_ST   = 4'd9
  } opcode_e;

  typedef enum logic {
    ST_IDLE     = 1'b0,
    ST_MUL_BUSY = 1'b1
  } ex_state_e;

  function automatic logic [DATA_W-1:0] sext_imm8(input logic [7:0] imm);
    return {{(DATA_W-8){imm[7]}}, imm};
  endfunction

endpackage

// File: rtl/ex_stage_if.sv
// ID/EX -> EX -> EX/MEM bus of the execute stage.
//   operand_a, operand_b, instruction_in : from ID/EX
//   ex_result, ex_store_data, ex_instruction : registered EX/MEM values
//   stall : high while upstream stages must hold
// Modports: master = upstream/downstream side, slave = ex_stage.
interface ex_stage_if #(
  parameter int DATA_W = proc_pkg::DATA_W
);
  logic [DATA_W-1:0] operand_a;
  logic [DATA_W-1:0] operand_b;
  logic [DATA_W-1:0] instruction_in;
  logic [DATA_W-1:0] ex_result;
  logic [DATA_W-1:0] ex_store_data;
  logic [DATA_W-1:0] ex_instruction;
  logic              stall;

  modport master (
    output operand_a, operand_b, instruction_in,
    input  ex_result, ex_store_data, ex_instruction, stall
  );

  modport slave (
    input  operand_a, operand_b, instruction_in,
    output ex_result, ex_store_data, ex_instruction, stall
  );
endinterface

// File: rtl/mul_seq.sv
// Iterative shift-add multiplier datapath, one multiplier bit per cycle.
//   clock, reset : rising-edge clock, synchronous active-high reset
//   start        : load i_a (multiplicand) / i_b (multiplier), clear accumulator
//   busy         : iterations in progress
//   last         : current cycle performs the final iteration
//   product      : accumulator value being written this cycle; equals the
//                  low DATA_W bits of i_a*i_b while last is high
module mul_seq #(
  parameter int DATA_W     = 20,
  parameter int MUL_CYCLES = 20
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic [DATA_W-1:0] i_a,
  input  logic [DATA_W-1:0] i_b,
  output logic              busy,
  output logic              last,
  output logic [DATA_W-1:0] product
);

  localparam int CNT_W = (MUL_CYCLES > 1) ? $clog2(MUL_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MUL_CYCLES - 1);

  logic [DATA_W-1:0] r_mcand;   // multiplicand, shifted left each iteration
  logic [DATA_W-1:0] r_mplier;  // multiplier, shifted right each iteration
  logic [DATA_W-1:0] r_acc;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_busy;

  logic [DATA_W-1:0] w_acc_nxt;
  logic              w_last;

  // Bits shifted out of the multiplicand only affect bits above DATA_W,
  // so the truncated accumulator is the wrapped product.
  assign w_acc_nxt = r_acc + (r_mplier[0] ? r_mcand : '0);
  assign w_last    = r_busy && (r_cnt == CNT_LAST);

  always_ff @(posedge clock) begin
    if (reset) begin
      r_mcand  <= '0;
      r_mplier <= '0;
      r_acc    <= '0;
      r_cnt    <= '0;
      r_busy   <= 1'b0;
    end else if (start) begin
      r_mcand  <= i_a;
      r_mplier <= i_b;
      r_acc    <= '0;
      r_cnt    <= '0;
      r_busy   <= 1'b1;
    end else if (r_busy) begin
      r_acc    <= w_acc_nxt;
      r_mcand  <= r_mcand << 1;
      r_mplier <= r_mplier >> 1;
      if (w_last) begin
        r_cnt  <= '0;
        r_busy <= 1'b0;
      end else begin
        r_cnt  <= r_cnt + 1'b1;
      end
    end
  end

  assign busy    = r_busy;
  assign last    = w_last;
  assign product = w_acc_nxt;

endmodule

// File: rtl/ex_stage.sv
// Execute stage of the 20-bit pipelined processor.
//   clock, reset : rising-edge clock, synchronous active-high reset
//   bus (ex_stage_if.slave):
//     operand_a/operand_b/instruction_in in from ID/EX
//     ex_result/ex_store_data/ex_instruction registered to EX/MEM (0 = bubble)
//     stall combinational, holds IF/ID and ID/EX during a multiply
// Build option: define EX_STAGE_MUL_EN to include the iterative multiplier
// (IDLE/MUL_BUSY FSM, mul_seq). Without it opcode 7 acts as NOP and stall
// is tied low.
module ex_stage #(
  parameter int DATA_W     = proc_pkg::DATA_W,
  parameter int MUL_CYCLES = proc_pkg::DATA_W
) (
  input  logic       clock,
  input  logic       reset,
  ex_stage_if.slave  bus
);
  import proc_pkg::*;

  if (DATA_W != 20 || MUL_CYCLES != DATA_W) begin : g_bad_cfg
    $error("ex_stage: only DATA_W = MUL_CYCLES = 20 is supported");
  end

  logic [3:0]        w_opc;
  logic [DATA_W-1:0] w_imm;
  logic [DATA_W-1:0] w_alu;
  logic              w_slt;

  logic [DATA_W-1:0] w_res_nxt;
  logic [DATA_W-1:0] w_sd_nxt;
  logic [DATA_W-1:0] w_ins_nxt;
  logic              w_stall;

  logic [DATA_W-1:0] r_result;
  logic [DATA_W-1:0] r_store;
  logic [DATA_W-1:0] r_instr;

  assign w_opc = bus.instruction_in[OPC_HI:OPC_LO];
  assign w_imm = sext_imm8(bus.instruction_in[IMM_HI:IMM_LO]);
  assign w_slt = $signed(bus.operand_a) < $signed(bus.operand_b);

  // Single-cycle ALU; MUL and unused opcodes yield 0 here.
  always_comb begin
    w_alu = '0;
    case (w_opc)
      OP_ADD:                w_alu = bus.operand_a + bus.operand_b;
      OP_SUB:                w_alu = bus.operand_a - bus.operand_b;
      OP_AND:                w_alu = bus.operand_a & bus.operand_b;
      OP_OR:                 w_alu = bus.operand_a | bus.operand_b;
      OP_SLT:                w_alu = {{(DATA_W-1){1'b0}}, w_slt};
      OP_ADDI, OP_LD, OP_ST: w_alu = bus.operand_a + w_imm;
      default:               w_alu = '0;
    endcase
  end

`ifdef EX_STAGE_MUL_EN
  ex_state_e         r_state;
  ex_state_e         w_state_nxt;
  logic              w_start;
  logic              w_busy;
  logic              w_last;
  logic [DATA_W-1:0] w_product;
  logic [DATA_W-1:0] r_mul_b;
  logic [DATA_W-1:0] r_mul_instr;

  mul_seq #(
    .DATA_W     (DATA_W),
    .MUL_CYCLES (MUL_CYCLES)
  ) u_mul_seq (
    .clock   (clock),
    .reset   (reset),
    .start   (w_start),
    .i_a     (bus.operand_a),
    .i_b     (bus.operand_b),
    .busy    (w_busy),
    .last    (w_last),
    .product (w_product)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_start     = 1'b0;
    w_stall     = 1'b0;
    w_res_nxt   = w_alu;
    w_sd_nxt    = bus.operand_b;
    w_ins_nxt   = bus.instruction_in;
    case (r_state)
      ST_IDLE: begin
        if (w_opc == OP_MUL) begin
          w_start     = 1'b1;
          w_stall     = 1'b1;
          w_state_nxt = ST_MUL_BUSY;
          w_res_nxt   = '0;
          w_sd_nxt    = '0;
          w_ins_nxt   = '0;
        end
      end
      ST_MUL_BUSY: begin
        // Stall drops on the final iteration so upstream advances in
        // step with the product landing in the output registers.
        w_stall = w_busy && !w_last;
        if (w_last) begin
          w_state_nxt = ST_IDLE;
          w_res_nxt   = w_product;
          w_sd_nxt    = r_mul_b;
          w_ins_nxt   = r_mul_instr;
        end else begin
          w_res_nxt   = '0;
          w_sd_nxt    = '0;
          w_ins_nxt   = '0;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
    if (reset) begin
      w_stall = 1'b0;
      w_start = 1'b0;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_mul_b     <= '0;
      r_mul_instr <= '0;
    end else if (w_start) begin
      r_mul_b     <= bus.operand_b;
      r_mul_instr <= bus.instruction_in;
    end
  end
`else
  always_comb begin
    w_stall   = 1'b0;
    w_res_nxt = w_alu;
    w_sd_nxt  = bus.operand_b;
    w_ins_nxt = bus.instruction_in;
  end
`endif

  always_ff @(posedge clock) begin
    if (reset) begin
      r_result <= '0;
      r_store  <= '0;
      r_instr  <= '0;
    end else begin
      r_result <= w_res_nxt;
      r_store  <= w_sd_nxt;
      r_instr  <= w_ins_nxt;
    end
  end

  assign bus.ex_result      = r_result;
  assign bus.ex_store_data  = r_store;
  assign bus.ex_instruction = r_instr;
  assign bus.stall          = w_stall;

endmodule

// File: doc/ex_stage.md
# ex_stage

Execute stage of the 20-bit pipelined processor, sitting directly downstream of `register_ID_EX` and feeding the EX/MEM boundary. It consumes the two register-file operands and the propagated instruction, computes the ALU result or the memory address, and registers the result, store data and instruction for the MEM stage. It also contains an iterative shift-add multiplier. While a multiply is in flight, the block raises `stall` so that IF/ID and ID/EX hold their contents.

## Interface
- `DATA_W`, default 20: datapath and instruction width; only 20 is supported.
- `MUL_CYCLES`, default 20: number of multiplier iterations; must equal `DATA_W`.

- `clock`  in  1  rising-edge clock.
- `reset`  in  1  reset, synchronous, active-high.
- `operand_a`  in  20  from ID/EX `dataRFOut1`.
- `operand_b`  in  20  from ID/EX `dataRFOut2`.
- `instruction_in`  in  20  from ID/EX `instructionPropagation`.
- `ex_result`  out  20  registered ALU result, address or product.
- `ex_store_data`  out  20  registered `operand_b`, used by ST.
- `ex_instruction`  out  20  registered instruction; value 0 means bubble.
- `stall`  out  1  combinational; high means upstream stages hold.

## Operation
- Instruction fields:
  - opcode = [19:16]
  - rd = [15:12]
  - rs1 = [11:8]
  - rs2 = [7:4]
  - imm8 = [7:0], sign-extended to 20 bits
- Opcodes and results:
  - 0 NOP
  - 1 ADD: a+b
  - 2 SUB: a−b
  - 3 AND
  - 4 OR
  - 5 SLT: signed compare, result 1 or 0
  - 6 ADDI: a+sext(imm8)
  - 7 MUL: low 20 bits of a×b
  - 8 LD: address a+sext(imm8)
  - 9 ST: address a+sext(imm8), store data b
  - Opcodes 10–15 behave as NOP: result 0 and instruction passed through unchanged.
- All arithmetic wraps modulo 2^20. Carries and overflow are discarded.
- FSM states: IDLE and MUL_BUSY.
  - IDLE, opcode is not MUL: register result, `operand_b` and `instruction_in` on each edge; state stays IDLE.
  - IDLE, opcode is MUL: `stall`=1 combinationally. Latch a, b and the instruction; clear the accumulator; set counter to 0; go to MUL_BUSY. Outputs load a bubble (all three outputs 0).
  - MUL_BUSY: one shift-add iteration per cycle and the counter increments. Inputs are ignored. Outputs hold the bubble.
    - `stall`=1 while counter < `MUL_CYCLES`−1.
    - On the iteration where counter = `MUL_CYCLES`−1: `stall`=0, and at the edge the product, latched b and latched instruction load into the outputs; state goes to IDLE.
- `stall`=0 whenever `reset`=1.

## Timing
- Reset values: `ex_result`, `ex_store_data` and `ex_instruction` are 0; `stall`=0. FSM is IDLE, counter and accumulator are 0.
- Non-MUL latency: 1 cycle from input to registered output.
- MUL presented in cycle 0:
  - `stall` is high in cycles 0–19 and low in cycle 20.
  - Outputs are bubbles for cycles 1–20.
  - The product is visible in cycle 21.
  - The next instruction is presented in cycle 21.
- Back-to-back MULs: the second starts in cycle 21, with no gap cycle.
- Reset during MUL_BUSY: the operation is abandoned. All outputs are 0 on the next cycle, no product is written, and `stall` drops in the reset cycle.
- Upstream must hold `instruction_in` and the operands stable while `stall`=1. The block does not rely on this: it latches its operands in cycle 0.

## Configuration
- `EX_STAGE_MUL_EN` defined: multiplier, MUL_BUSY state and stall behaviour are as described above.
- `EX_STAGE_MUL_EN` undefined:
  - Opcode 7 behaves as NOP (result 0, instruction passed through).
  - `stall` is tied to 0.
  - The FSM, counter and `mul_seq` instance are not compiled.

## Structure
- Shared package `proc_pkg` holds:
  - `DATA_W`
  - opcode constants `OP_NOP` … `OP_ST`
  - field bit positions and the opcode type
- Sub-module `mul_seq` holds the iterative multiplier datapath (multiplier shift register, accumulator, counter) and provides `start`, `busy`, `last` and `product`. `ex_stage` owns the FSM and the output registers.

## Test plan
- Reset mid-stream: assert `reset` for 1 cycle while outputs are non-zero → all outputs 0, `stall`=0 on the next cycle.
- ADD a=0xFFFFF, b=0x00002 → next cycle `ex_result`=0x00001. SLT a=0x80000, b=0x00001 → next cycle `ex_result`=1.
- ADDI with imm8=0xFE, a=0x00010 → `ex_result`=0x0000E. ST a=0x00100, imm8=0x04, b=0x12345 → `ex_result`=0x00104, `ex_store_data`=0x12345.
- MUL a=0x00123, b=0x00045 → `stall` high for exactly 20 cycles, bubbles for 20 cycles, then `ex_result`=0x04E6F with `ex_instruction` equal to the MUL.
- MUL a=0xFFFFF, b=0xFFFFF → product 0x00001. An ADD immediately behind it → `ex_result` of the ADD appears 1 cycle after the product.
- `reset` in cycle 10 of a MUL → no product emitted, `stall`=0, next ADD completes normally. Build without `EX_STAGE_MUL_EN`, apply MUL → `stall` never rises, `ex_result`=0.
